prbs_axil_slave: RTL and testbench

PRBS_AXIL_SLAVE -- requirements
Module: prbs_axil_slave

---
 rtl/prbs_axil_pkg.sv | 60 ++++++
 rtl/prbs_lfsr.sv | 42 ++++
 rtl/prbs_axil_slave.sv | 146 ++++++++++++++
 tb/tb_prbs_axil_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_axil_pkg.sv
// Shared definitions for the PRBS AXI4-Lite slave: register map, CTRL fields,
// polynomial select and the LFSR tap helpers used by generator and checker.
package prbs_axil_pkg;

  localparam int LFSR_W = 31;

  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_SEED    = 4'h4;
  localparam logic [3:0] REG_SCRATCH = 4'h8;
  localparam logic [3:0] REG_STATUS  = 4'hC;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_LOAD_BIT = 1;
  localparam int CTRL_POLY_LSB = 2;

  typedef enum logic [1:0] {
    POLY_PRBS7  = 2'd0,
    POLY_PRBS15 = 2'd1,
    POLY_PRBS23 = 2'd2,
    POLY_PRBS31 = 2'd3
  } poly_e;

  // Bit i of a mask selects state bit i (term x^(i+1)) as a feedback tap.
  localparam logic [LFSR_W-1:0] TAP_PRBS7  = 31'h0000_0060;
  localparam logic [LFSR_W-1:0] TAP_PRBS15 = 31'h0000_6000;
  localparam logic [LFSR_W-1:0] TAP_PRBS23 = 31'h0042_0000;
  localparam logic [LFSR_W-1:0] TAP_PRBS31 = 31'h4800_0000;

  function automatic logic [LFSR_W-1:0] tap_mask(poly_e p);
    case (p)
      POLY_PRBS7:  return TAP_PRBS7;
      POLY_PRBS15: return TAP_PRBS15;
      POLY_PRBS23: return TAP_PRBS23;
      default:     return TAP_PRBS31;
    endcase
  endfunction

  function automatic logic lfsr_fb(logic [LFSR_W-1:0] s, poly_e p);
    return ^(s & tap_mask(p));
  endfunction

  function automatic logic [4:0] msb_idx(poly_e p);
    case (p)
      POLY_PRBS7:  return 5'd6;
      POLY_PRBS15: return 5'd14;
      POLY_PRBS23: return 5'd22;
      default:     return 5'd30;
    endcase
  endfunction

  function automatic logic [31:0] apply_strb(logic [31:0] cur, logic [31:0] wd,
                                             logic [3:0] strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// 31-bit Fibonacci LFSR with selectable polynomial, seed load and enable.
module prbs_lfsr
  import prbs_axil_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              load_i,
  input  poly_e             poly_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] state_o,
  output logic              bit_o,
  output logic              valid_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              bit_q, valid_q;

  // Zero seed would lock the register; substitute all-ones.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)    lfsr_d = (seed_i == '0) ? '1 : seed_i;
    else if (en_i) lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q, poly_i)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q  <= '1;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      bit_q   <= lfsr_q[msb_idx(poly_i)];
      valid_q <= en_i;
    end
  end

  assign state_o = lfsr_q;
  assign bit_o   = bit_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/prbs_axil_slave.sv
// AXI4-Lite controlled PRBS generator. Define PRBS_CHECKER_EN to add the
// self-synchronising receive checker whose error count replaces STATUS.
module prbs_axil_slave
  import prbs_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            prbs_bit,
  output logic                            prbs_valid,
  input  logic                            prbs_rx_bit
);

  logic              awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]       rdata_q, rd_val, status_val;
  logic [31:0]       seed_q, scratch_q;
  logic              en_q, load_q;
  poly_e             poly_q;
  logic [LFSR_W-1:0] lfsr_state;
  logic              wr_fire, rd_fire;

  assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready_q & S_AXI_ARVALID;

  prbs_lfsr u_lfsr (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .en_i    (en_q),
    .load_i  (load_q),
    .poly_i  (poly_q),
    .seed_i  (seed_q[LFSR_W-1:0]),
    .state_o (lfsr_state),
    .bit_o   (prbs_bit),
    .valid_o (prbs_valid)
  );

`ifdef PRBS_CHECKER_EN
  logic [LFSR_W-1:0] rx_sr_q;
  logic [31:0]       err_cnt_q;
  logic              rx_err;
  logic              unused_ok;

  // The received stream obeys the generator recurrence, so the same taps
  // applied to the last received bits predict the next one.
  assign rx_err     = prbs_valid & en_q & (lfsr_fb(rx_sr_q, poly_q) != prbs_rx_bit);
  assign status_val = err_cnt_q;
  assign unused_ok  = ^{lfsr_state, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_sr_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (prbs_valid) rx_sr_q <= {rx_sr_q[LFSR_W-2:0], prbs_rx_bit};
      if (wr_fire && S_AXI_AWADDR[3:2] == REG_STATUS[3:2]) err_cnt_q <= '0;
      else if (rx_err && err_cnt_q != '1)                  err_cnt_q <= err_cnt_q + 32'd1;
    end
  end
`else
  logic unused_ok;
  assign status_val = {1'b0, lfsr_state};
  assign unused_ok  = ^{prbs_rx_bit, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`endif

  always_comb begin
    rd_val = '0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL[3:2]:    rd_val = {28'b0, poly_q, 1'b0, en_q};
      REG_SEED[3:2]:    rd_val = seed_q;
      REG_SCRATCH[3:2]: rd_val = scratch_q;
      default:          rd_val = status_val;
    endcase
  end

  // Read samples registers before this edge's write lands: pre-write value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      load_q    <= 1'b0;
      poly_q    <= POLY_PRBS7;
      seed_q    <= '0;
      scratch_q <= '0;
    end else begin
      awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;

      if (wr_fire)           bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;

      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      load_q <= 1'b0;
      if (wr_fire) begin
        case (S_AXI_AWADDR[3:2])
          REG_CTRL[3:2]: if (S_AXI_WSTRB[0]) begin
            en_q   <= S_AXI_WDATA[CTRL_EN_BIT];
            load_q <= S_AXI_WDATA[CTRL_LOAD_BIT];
            poly_q <= poly_e'(S_AXI_WDATA[CTRL_POLY_LSB +: 2]);
          end
          REG_SEED[3:2]:    seed_q    <= apply_strb(seed_q, S_AXI_WDATA, S_AXI_WSTRB);
          REG_SCRATCH[3:2]: scratch_q <= apply_strb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

endmodule

// File: tb/tb_prbs_axil_slave.sv
// Directed + randomized bench for prbs_axil_slave: register map, AXI handshakes,
// PRBS sequences against a recurrence model, reset behaviour, optional checker.
module tb_prbs_axil_slave;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        prbs_bit, prbs_valid, rx_flip;
  wire         prbs_rx_bit = prbs_bit ^ rx_flip;

  int tests = 0;
  int fails = 0;

`ifdef PRBS_CHECKER_EN
  localparam logic [31:0] STATUS_IDLE = 32'h0;
`else
  localparam logic [31:0] STATUS_IDLE = 32'h7FFF_FFFF;
`endif

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  prbs_axil_slave dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .prbs_bit(prbs_bit), .prbs_valid(prbs_valid), .prbs_rx_bit(prbs_rx_bit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge S_AXI_ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge S_AXI_ACLK); n++; end
    check("wr_accept", {30'b0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge S_AXI_ACLK); n++; end
    check("bresp", {29'b0, S_AXI_BVALID, S_AXI_BRESP}, 32'h4);
    if (S_AXI_BREADY) begin @(posedge S_AXI_ACLK); #1; end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(negedge S_AXI_ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge S_AXI_ACLK); n++; end
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(negedge S_AXI_ACLK); n++; end
    check("rvalid_rresp", {29'b0, S_AXI_RVALID, S_AXI_RRESP}, 32'h4);
    d = S_AXI_RDATA;
    if (S_AXI_RREADY) begin @(posedge S_AXI_ACLK); #1; end
  endtask

  // Reference: output sequence of x^n + x^k + 1 obeys b[t] = b[t-n] ^ b[t-k],
  // with the first n bits being the seed read from bit n-1 downwards.
  function automatic logic [299:0] model_seq(input logic [1:0] p, input logic [31:0] seed);
    logic [299:0] b;
    logic [30:0]  st;
    int n, k;
    case (p)
      2'd0: begin n = 7;  k = 6;  end
      2'd1: begin n = 15; k = 14; end
      2'd2: begin n = 23; k = 18; end
      default: begin n = 31; k = 28; end
    endcase
    st = (seed[30:0] == 31'd0) ? 31'h7FFF_FFFF : seed[30:0];
    b = '0;
    for (int j = 0; j < 300; j++)
      b[j] = (j < n) ? st[n-1-j] : (b[j-n] ^ b[j-k]);
    return b;
  endfunction

  // Restart the generator from a seed and capture nb consecutive new bits.
  task automatic run_prbs(input logic [1:0] p, input logic [31:0] seed, input int nb,
                          output logic [299:0] got);
    int cnt, guard;
    bit first;
    got = '0;
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, seed, 4'hF);
    axi_write(4'h0, {28'b0, p, 2'b11}, 4'h1);
    cnt = 0; guard = 0; first = 1'b1;
    while (cnt < nb && guard < 2000) begin
      @(negedge S_AXI_ACLK); guard++;
      if (prbs_valid) begin
        if (first) first = 1'b0;
        else begin got[cnt] = prbs_bit; cnt++; end
      end
    end
    check("prbs_capture_count", cnt, nb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rd, rd2, m_seed, m_scratch, d;
    logic [3:0]   s, a;
    logic [1:0]   p;
    logic [299:0] got, exp;
    int           mism, ones;

    S_AXI_ARESETN = 1'b0; rx_flip = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    repeat (3) @(negedge S_AXI_ACLK);
    check("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                            S_AXI_RVALID, prbs_bit, prbs_valid}, 32'h0);
    check("reset_rdata", S_AXI_RDATA, 32'h0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge S_AXI_ACLK); S_AXI_ARESETN = 1'b1;

    axi_read(4'h0, rd); check("reset_ctrl", rd, 32'h0);
    axi_read(4'h8, rd); check("reset_scratch", rd, 32'h0);
    axi_read(4'hC, rd); check("reset_status", rd, STATUS_IDLE);

    // Register map, STATUS write ignored (or count cleared)
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'hC, rd); check("status_ro", rd, STATUS_IDLE);
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_read(4'h0, rd); check("map_ctrl", rd, 32'h1);
    axi_read(4'h4, rd); check("map_seed", rd, 32'h2);
    axi_read(4'h8, rd); check("map_scratch", rd, 32'h3);
    m_seed = 32'h2; m_scratch = 32'h3;

    // Random writes with byte strobes against a merged-byte model
    for (int i = 0; i < 8; i++) begin
      d = $urandom; s = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 1) == 0) ? 4'h4 : 4'h8;
      axi_write(a, d, s);
      for (int b = 0; b < 4; b++)
        if (s[b]) begin
          if (a == 4'h4) m_seed[8*b +: 8] = d[8*b +: 8];
          else           m_scratch[8*b +: 8] = d[8*b +: 8];
        end
      axi_read(4'h4, rd); check("rand_seed", rd, m_seed);
      axi_read(4'h8, rd); check("rand_scratch", rd, m_scratch);
    end

    // Same-cycle read and write of SCRATCH: read sees the old value
    d = $urandom;
    fork
      axi_write(4'h8, d, 4'hF);
      axi_read(4'h8, rd2);
    join
    check("simul_read_old", rd2, m_scratch);
    m_scratch = d;
    axi_read(4'h8, rd); check("simul_after", rd, m_scratch);

    // BREADY held low: BVALID holds and no second write is accepted
    S_AXI_BREADY = 1'b0;
    axi_write(4'h8, 32'hA5A5_0001, 4'hF);
    @(negedge S_AXI_ACLK);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h5A5A_0002; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge S_AXI_ACLK);
      if (!S_AXI_BVALID || S_AXI_AWREADY) mism++;
    end
    check("bready_hold", mism, 0);
    S_AXI_BREADY = 1'b1;
    mism = 0;
    while (!S_AXI_AWREADY && mism < 50) begin @(negedge S_AXI_ACLK); mism++; end
    check("second_write_accept", {31'b0, S_AXI_AWREADY}, 32'd1);
    @(posedge S_AXI_ACLK); #1; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (3) @(negedge S_AXI_ACLK);
    m_scratch = 32'h5A5A_0002;
    axi_read(4'h8, rd); check("second_write_data", rd, m_scratch);

    // Zero seed loads all-ones and does not lock up
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h0, 4'hF);
    axi_write(4'h0, 32'h2, 4'hF);
    axi_read(4'hC, rd); check("zero_seed_status", rd, STATUS_IDLE);
    axi_read(4'h0, rd); check("load_reads_zero", rd, 32'h0);
    p = 2'($urandom_range(0, 3));
    run_prbs(p, 32'h0, 80, got);
    exp = model_seq(p, 32'h0);
    mism = 0; ones = 0;
    for (int i = 0; i < 80; i++) begin
      if (got[i] !== exp[i]) mism++;
      if (i >= 40 && got[i]) ones++;
    end
    check("zero_seed_seq", mism, 0);
    check("no_lockup", {31'b0, ones != 0}, 32'd1);

    // PRBS7 from 0x7F: model match and period 127
    run_prbs(2'd0, 32'h7F, 254, got);
    exp = model_seq(2'd0, 32'h7F);
    mism = 0;
    for (int i = 0; i < 254; i++) if (got[i] !== exp[i]) mism++;
    check("prbs7_seq", mism, 0);
    mism = 0;
    for (int i = 0; i < 127; i++) if (got[i] !== got[i+127]) mism++;
    check("prbs7_period", mism, 0);

    // Random polynomial / seed rounds
    for (int r = 0; r < 4; r++) begin
      p = 2'($urandom_range(0, 3));
      d = $urandom | 32'h1;
      run_prbs(p, d, 100, got);
      exp = model_seq(p, d);
      mism = 0;
      for (int i = 0; i < 100; i++) if (got[i] !== exp[i]) mism++;
      check("rand_poly_seq", mism, 0);
    end

`ifdef PRBS_CHECKER_EN
    // Loopback with one flipped bit: error plus two tap echoes
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h7F, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (40) @(negedge S_AXI_ACLK);
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF);
    axi_read(4'hC, rd); check("chk_clean", rd, 32'h0);
    while (!prbs_valid) @(negedge S_AXI_ACLK);
    rx_flip = 1'b1;
    @(negedge S_AXI_ACLK);
    rx_flip = 1'b0;
    repeat (20) @(negedge S_AXI_ACLK);
    axi_read(4'hC, rd); check("chk_three_errors", rd, 32'h3);
    axi_write(4'hC, 32'h0, 4'hF);
    axi_read(4'hC, rd); check("chk_clear", rd, 32'h0);
`endif

    // Asynchronous reset while a read response is pending
    axi_write(4'h0, 32'h0, 4'hF);
    S_AXI_RREADY = 1'b0;
    axi_read(4'h8, rd); check("pending_read", rd, m_scratch);
    #2 S_AXI_ARESETN = 1'b0;
    #1 check("async_rvalid_rdata", {31'b0, S_AXI_RVALID} | S_AXI_RDATA, 32'h0);
    repeat (2) @(negedge S_AXI_ACLK);
    S_AXI_RREADY = 1'b1; S_AXI_ARESETN = 1'b1;
    axi_read(4'h0, rd); check("post_reset_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); check("post_reset_seed", rd, 32'h0);
    axi_read(4'h8, rd); check("post_reset_scratch", rd, 32'h0);
    axi_read(4'hC, rd); check("post_reset_status", rd, STATUS_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
